tank_move_sched: RTL and testbench

//  Per-frame scheduler that feeds direction commands to the two tank datapath blocks.

---
 rtl/tank_pkg.sv | 24 ++
 rtl/tank_move_sched_if.sv | 25 ++
 rtl/tank_collide_chk.sv | 40 ++++
 rtl/tank_move_sched.sv | 112 +++++++++++
 tb/tb_tank_move_sched.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/tank_pkg.sv
// Shared types and constants for the tank move scheduler and its collision checker.
package tank_pkg;

  typedef enum logic [2:0] {
    UP    = 3'd0,
    DOWN  = 3'd1,
    LEFT  = 3'd2,
    RIGHT = 3'd3,
    STAND = 3'd4
  } dir_e;

  localparam logic [1:0] GS_PLAY    = 2'b01;
  localparam logic [1:0] GS_RESTART = 2'b10;

  typedef enum logic [2:0] {
    StWait,
    StChkA,
    StIssueA,
    StSettle,
    StChkB,
    StIssueB
  } sched_state_e;

endpackage

// File: rtl/tank_move_sched_if.sv
// Bundle between game/joystick logic (master) and the move scheduler (slave).
interface tank_move_sched_if;
  logic [1:0] game_state;
  logic [2:0] dir_req0;
  logic [2:0] dir_req1;
  logic [5:0] pos_x0;
  logic [5:0] pos_y0;
  logic [5:0] pos_x1;
  logic [5:0] pos_y1;
  logic [1:0] take_valid;
  logic [2:0] dir_cmd0;
  logic [2:0] dir_cmd1;
  logic [1:0] blocked;
  logic       frame_tick;

  modport master (
    output game_state, dir_req0, dir_req1, pos_x0, pos_y0, pos_x1, pos_y1,
    input  take_valid, dir_cmd0, dir_cmd1, blocked, frame_tick
  );

  modport slave (
    input  game_state, dir_req0, dir_req1, pos_x0, pos_y0, pos_x1, pos_y1,
    output take_valid, dir_cmd0, dir_cmd1, blocked, frame_tick
  );
endinterface

// File: rtl/tank_collide_chk.sv
// Combinational check: would a one-cell step leave the field or overlap the other tank?
module tank_collide_chk
  import tank_pkg::*;
#(
  parameter int unsigned FIELD_MAX = 39,
  parameter int unsigned TANK_HALF = 1
) (
  input  logic [2:0] req_i,
  input  logic [5:0] own_x_i,
  input  logic [5:0] own_y_i,
  input  logic [5:0] oth_x_i,
  input  logic [5:0] oth_y_i,
  output logic       blocked_o
);

  int  tx, ty, dx, dy;
  logic moves, oob;

  always_comb begin
    tx    = int'(own_x_i);
    ty    = int'(own_y_i);
    moves = 1'b1;
    case (req_i)
      UP:      ty = ty - 1;
      DOWN:    ty = ty + 1;
      LEFT:    tx = tx - 1;
      RIGHT:   tx = tx + 1;
      default: moves = 1'b0;
    endcase
    // Signed arithmetic keeps a step off the zero edge negative instead of wrapping.
    oob = (tx < int'(TANK_HALF)) || (tx > int'(FIELD_MAX) - int'(TANK_HALF)) ||
          (ty < int'(TANK_HALF)) || (ty > int'(FIELD_MAX) - int'(TANK_HALF));
    dx  = tx - int'(oth_x_i);
    dy  = ty - int'(oth_y_i);
    if (dx < 0) dx = -dx;
    if (dy < 0) dy = -dy;
    blocked_o = moves && (oob || ((dx <= 2 * int'(TANK_HALF)) && (dy <= 2 * int'(TANK_HALF))));
  end

endmodule

// File: rtl/tank_move_sched.sv
// Frame-tick generator and round-robin scheduler issuing one direction command per tank
// per frame, replacing blocked moves with STAND.
module tank_move_sched
  import tank_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 833_333,
  parameter int unsigned FIELD_MAX = 39,
  parameter int unsigned TANK_HALF = 1
) (
  input logic              clk,
  input logic              rst_n,
  tank_move_sched_if.slave bus
);

  localparam int unsigned CntW = $clog2(TICK_DIV);

  logic [CntW-1:0]  tick_cnt_q, tick_cnt_d;
  sched_state_e     state_q, state_d;
  logic             first_q, first_d;
  logic [1:0]       take_valid_q, take_valid_d;
  logic [1:0]       blocked_q, blocked_d;
  logic [1:0][2:0]  dir_cmd_q, dir_cmd_d;

  logic       frame_tick, play;
  logic       cur, cur_blk;
  logic [2:0] cur_req;
  logic [5:0] own_x, own_y, oth_x, oth_y;

  assign frame_tick = (tick_cnt_q == CntW'(TICK_DIV - 1));
  assign play       = (bus.game_state == GS_PLAY);

  // A single checker is shared: it looks at tank B only while in CHK_B.
  always_comb begin
    cur     = (state_q == StChkB) ? ~first_q : first_q;
    cur_req = cur ? bus.dir_req1 : bus.dir_req0;
    own_x   = cur ? bus.pos_x1 : bus.pos_x0;
    own_y   = cur ? bus.pos_y1 : bus.pos_y0;
    oth_x   = cur ? bus.pos_x0 : bus.pos_x1;
    oth_y   = cur ? bus.pos_y0 : bus.pos_y1;
  end

  tank_collide_chk #(
    .FIELD_MAX (FIELD_MAX),
    .TANK_HALF (TANK_HALF)
  ) u_collide_chk (
    .req_i     (cur_req),
    .own_x_i   (own_x),
    .own_y_i   (own_y),
    .oth_x_i   (oth_x),
    .oth_y_i   (oth_y),
    .blocked_o (cur_blk)
  );

  always_comb begin
    tick_cnt_d   = frame_tick ? '0 : tick_cnt_q + 1'b1;
    state_d      = state_q;
    first_d      = first_q;
    take_valid_d = 2'b00;
    blocked_d    = blocked_q;
    dir_cmd_d    = dir_cmd_q;

    unique case (state_q)
      StWait: if (frame_tick && play) state_d = StChkA;
      // Outputs are loaded here so they appear together with the pulse in ISSUE.
      StChkA, StChkB: begin
        take_valid_d[cur] = 1'b1;
        blocked_d[cur]    = cur_blk;
        dir_cmd_d[cur]    = (cur_blk || (cur_req > STAND)) ? STAND : cur_req;
        state_d           = (state_q == StChkA) ? StIssueA : StIssueB;
      end
      StIssueA: state_d = play ? StSettle : StWait;
      StSettle: state_d = play ? StChkB : StWait;
      StIssueB: begin
        first_d = ~first_q;
        state_d = StWait;
      end
      default: state_d = StWait;
    endcase

    if (bus.game_state == GS_RESTART) begin
      blocked_d    = 2'b00;
      dir_cmd_d[0] = STAND;
      dir_cmd_d[1] = STAND;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q   <= '0;
      state_q      <= StWait;
      first_q      <= 1'b0;
      take_valid_q <= 2'b00;
      blocked_q    <= 2'b00;
      dir_cmd_q[0] <= STAND;
      dir_cmd_q[1] <= STAND;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      first_q      <= first_d;
      take_valid_q <= take_valid_d;
      blocked_q    <= blocked_d;
      dir_cmd_q    <= dir_cmd_d;
    end
  end

  assign bus.take_valid = take_valid_q;
  assign bus.blocked    = blocked_q;
  assign bus.dir_cmd0   = dir_cmd_q[0];
  assign bus.dir_cmd1   = dir_cmd_q[1];
  assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_tank_move_sched.sv
// Scoreboard bench for tank_move_sched: directed frames push expected pulses, a monitor
// pops and compares whenever take_valid is seen.
module tb_tank_move_sched;

  typedef struct {
    int tv;
    int cmd0;
    int cmd1;
    int blk;
    int off;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tick_cyc = 0;
  int   m_cmd[2];
  int   m_blk[2];
  exp_t sb[$];

  tank_move_sched_if bus ();

  tank_move_sched #(
    .TICK_DIV  (16),
    .FIELD_MAX (39),
    .TANK_HALF (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: samples on the falling edge, away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.frame_tick) tick_cyc = cyc;
      if (bus.take_valid != 2'b00) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", int'(bus.take_valid), 0);
        end else begin
          e = sb.pop_front();
          check("take_valid", int'(bus.take_valid), e.tv);
          check("dir_cmd0", int'(bus.dir_cmd0), e.cmd0);
          check("dir_cmd1", int'(bus.dir_cmd1), e.cmd1);
          check("blocked", int'(bus.blocked), e.blk);
          check("latency", cyc - tick_cyc, e.off);
        end
      end
    end
  end

  task automatic push_exp(input int idx, input int cmd, input int blk, input int off);
    exp_t e;
    m_cmd[idx] = cmd;
    m_blk[idx] = blk;
    e.tv   = 1 << idx;
    e.cmd0 = m_cmd[0];
    e.cmd1 = m_cmd[1];
    e.blk  = m_blk[0] + 2 * m_blk[1];
    e.off  = off;
    sb.push_back(e);
  endtask

  task automatic set_in(input int x0, input int y0, input int r0,
                        input int x1, input int y1, input int r1);
    bus.pos_x0   = 6'(x0);
    bus.pos_y0   = 6'(y0);
    bus.dir_req0 = 3'(r0);
    bus.pos_x1   = 6'(x1);
    bus.pos_y1   = 6'(y1);
    bus.dir_req1 = 3'(r1);
  endtask

  // Waits at falling edges for frame_tick; n = edges taken, bounded.
  task automatic wait_tick(output int n);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.frame_tick) begin
        n = k;
        break;
      end
    end
    if (n == 0) check("frame_tick_timeout", 0, 1);
  endtask

  task automatic frame();
    int n;
    wait_tick(n);
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int n;
    m_cmd[0] = 4; m_cmd[1] = 4;
    m_blk[0] = 0; m_blk[1] = 0;
    bus.game_state = 2'b01;
    set_in(10, 10, 3, 30, 30, 0);

    // 1: reset values, first tick at TICK_DIV-1
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_take_valid", int'(bus.take_valid), 0);
    check("rst_dir_cmd0", int'(bus.dir_cmd0), 4);
    check("rst_dir_cmd1", int'(bus.dir_cmd1), 4);
    check("rst_blocked", int'(bus.blocked), 0);
    check("rst_frame_tick", int'(bus.frame_tick), 0);

    // 2: basic frame, tank0 first
    push_exp(0, 3, 0, 2);
    push_exp(1, 0, 0, 5);
    rst_n = 1'b1;
    wait_tick(n);
    check("first_tick_cycle", n, 15);
    repeat (8) @(negedge clk);

    // 3: overlap, tank1 first now
    set_in(10, 10, 3, 13, 10, 4);
    push_exp(1, 4, 0, 2);
    push_exp(0, 4, 1, 5);
    frame();
    set_in(10, 10, 3, 14, 10, 7);
    push_exp(0, 3, 0, 2);
    push_exp(1, 4, 0, 5);
    frame();

    // 4: field bounds
    set_in(1, 20, 2, 30, 30, 1);
    push_exp(1, 1, 0, 2);
    push_exp(0, 4, 1, 5);
    frame();
    set_in(38, 20, 3, 10, 10, 2);
    push_exp(0, 4, 1, 2);
    push_exp(1, 2, 0, 5);
    frame();
    set_in(37, 20, 3, 10, 1, 0);
    push_exp(1, 4, 1, 2);
    push_exp(0, 3, 0, 5);
    frame();

    // 5: leave PLAY during SETTLE, then RESTART
    set_in(10, 10, 3, 30, 30, 0);
    push_exp(0, 3, 0, 2);
    wait_tick(n);
    repeat (3) @(negedge clk);
    bus.game_state = 2'b00;
    repeat (20) @(negedge clk);
    check("abort_sb_empty", sb.size(), 0);
    check("pre_restart_blocked", int'(bus.blocked), 2);
    check("pre_restart_cmd0", int'(bus.dir_cmd0), 3);
    bus.game_state = 2'b10;
    @(negedge clk);
    check("restart_blocked", int'(bus.blocked), 0);
    check("restart_cmd0", int'(bus.dir_cmd0), 4);
    check("restart_cmd1", int'(bus.dir_cmd1), 4);
    m_cmd[0] = 4; m_cmd[1] = 4;
    m_blk[0] = 0; m_blk[1] = 0;

    // 6: async reset while in ISSUE_A
    bus.game_state = 2'b01;
    wait_tick(n);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("issue_a_pulse", int'(bus.take_valid), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_take_valid", int'(bus.take_valid), 0);
    check("async_rst_cmd0", int'(bus.dir_cmd0), 4);
    check("async_rst_blocked", int'(bus.blocked), 0);
    @(negedge clk);
    push_exp(0, 3, 0, 2);
    push_exp(1, 0, 0, 5);
    rst_n = 1'b1;
    wait_tick(n);
    check("post_rst_tick_cycle", n, 15);
    repeat (8) @(negedge clk);

    check("final_sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
